multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 8'd255: maximum cycles spent waiting for a memory hit before timeout.
REQ-002 SHALL have port CLK, input, 1: system clock; all state updates on rising edge.
REQ-003 SHALL have port nRST, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port instr, input, 32: instruction register contents; opcode = instr[31:26].
REQ-005 SHALL have port ihit, input, 1: instruction memory read complete.
REQ-006 SHALL have port dhit, input, 1: data memory access complete.
REQ-007 SHALL have port zero, input, 1: ALU zero flag, valid in EXEC.
REQ-008 SHALL have outputs iREN, dREN, dWEN, IRWrite, PCWrite, ExtOp, ALUSrc, RegWrite, MemToReg, halt, timeout, each 1 bit: datapath and memory controls.
REQ-009 SHALL have output PCSrc, 2 bits: 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-010 SHALL have output state, 3 bits: current FSM state encoding.

Function
REQ-011 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6 and 7 SHALL go to FETCH on the next cycle.
REQ-012 In FETCH, SHALL assert iREN. On ihit, SHALL assert IRWrite and PCWrite with PCSrc=0, and SHALL move to DECODE on the next edge. Without ihit, SHALL stay in FETCH.
REQ-013 From DECODE, SHALL go to HALT if opcode is 6'h3F; otherwise SHALL go to EXEC.
REQ-014 ExtOp SHALL be 1 (sign-extend) for opcodes ADDIU 09, SLTI 0A, SLTIU 0B, LW 23, SW 2B, BEQ 04, BNE 05.
REQ-015 ExtOp SHALL be 0 (zero-extend) for ANDI 0C, ORI 0D, XORI 0E, LUI 0F, and for all other opcodes.
REQ-016 ExtOp SHALL be a combinational function of opcode and SHALL be valid in every state except HALT.
REQ-017 ALUSrc SHALL be 1 for all I-type ALU opcodes and for LW/SW; it SHALL be 0 for R-type (00), BEQ and BNE.
REQ-018 In EXEC:
- BEQ with zero=1, or BNE with zero=0: SHALL pulse PCWrite with PCSrc=1.
- Branches and J (02) SHALL return to FETCH; J SHALL pulse PCWrite with PCSrc=2.
- JAL (03) SHALL pulse PCWrite with PCSrc=2 and SHALL go to WB.
- LW and SW SHALL go to MEM; all other opcodes SHALL go to WB.
REQ-019 In MEM, SHALL assert dREN for LW or dWEN for SW, never both. On dhit, LW SHALL go to WB and SW SHALL go to FETCH; otherwise SHALL stay in MEM.
REQ-020 In WB, SHALL assert RegWrite for one cycle, with MemToReg=1 only for LW, then SHALL go to FETCH.
REQ-021 HALT SHALL be absorbing until reset. In HALT, halt SHALL be 1 and all request and write-enable outputs SHALL be 0.
REQ-022 SHALL keep an 8-bit wait counter:
- cleared on entering FETCH or MEM, and on any hit;
- incremented each cycle spent in FETCH or MEM without a hit;
- when it reaches WAIT_MAX, SHALL set timeout (sticky) and go to HALT.
REQ-023 If ihit and dhit arrive together, SHALL honour only the hit for the current state's request and ignore the other.
REQ-024 PCWrite, IRWrite and RegWrite SHALL each be single-cycle pulses per instruction.

Reset
REQ-025 While nRST=0 at a clock edge, SHALL set state=FETCH, wait counter=0, halt=0, timeout=0.
REQ-026 In reset, all enable/request outputs other than iREN SHALL be 0.
REQ-027 Reset asserted mid-MEM SHALL drop dREN/dWEN on the next cycle with no RegWrite issued.

Verification
REQ-028 ADDIU (instr=32'h2401FFFF), ihit on cycle 2: states FETCH, DECODE, EXEC, WB, FETCH; ExtOp=1, ALUSrc=1; RegWrite pulses once, in WB.
REQ-029 ORI (32'h3401FFFF): ExtOp=0 throughout; same state sequence as REQ-028.
REQ-030 LW with dhit delayed 3 cycles: MEM held 4 cycles with dREN=1 and dWEN=0; WB has MemToReg=1.
REQ-031 BEQ with zero=1: PCWrite=1 and PCSrc=1 in EXEC, then FETCH. With zero=0: no PCWrite in EXEC.
REQ-032 ihit never asserted, WAIT_MAX=4: timeout=1 and state=HALT after 4 cycles; reset then clears both.
REQ-033 instr=32'hFC000000: HALT reached after DECODE; halt stays 1 for 20 cycles.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-hit wait counter with sticky timeout, and an absorbing halt state.
//
// state  | meaning
// FETCH  | request instruction; on ihit latch IR and advance PC
// DECODE | opcode available; HALT opcode diverts to HALT
// EXEC   | ALU operation, branch/jump PC update
// MEM    | data memory read (LW) or write (SW) until dhit
// WB     | register file write, then back to FETCH
// HALT   | absorbing until reset; all requests and enables low
module multicycle_control #(
  parameter logic [7:0] WAIT_MAX = 8'd255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] instr,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        zero,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        ExtOp,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        halt,
  output logic        timeout,
  output logic [1:0]  PCSrc,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  state_t     cur;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       timeout_set;
  logic [5:0] opc;
  logic       is_lw;
  logic       is_sw;
  logic       take_branch;
  logic       unused_instr;

  assign opc          = instr[31:26];
  assign unused_instr = ^instr[25:0];
  assign is_lw        = (opc == OP_LW);
  assign is_sw        = (opc == OP_SW);
  assign take_branch  = ((opc == OP_BEQ) && zero) || ((opc == OP_BNE) && !zero);
  assign state        = cur;

  always_comb begin
    ExtOp = 1'b0;
    case (opc)
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_BEQ, OP_BNE: ExtOp = 1'b1;
      default: ExtOp = 1'b0;
    endcase
  end

  always_comb begin
    ALUSrc = 1'b0;
    case (opc)
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LW, OP_SW: ALUSrc = 1'b1;
      OP_RTYPE, OP_BEQ, OP_BNE: ALUSrc = 1'b0;
      default: ALUSrc = 1'b0;
    endcase
  end

  always_comb begin
    nxt         = cur;
    wait_nxt    = 8'd0;
    timeout_set = 1'b0;
    iREN        = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 2'd0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    halt        = 1'b0;

    case (cur)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = DECODE;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
          if (wait_nxt == WAIT_MAX) begin
            timeout_set = 1'b1;
            nxt         = HALT;
          end
        end
      end
      DECODE: nxt = (opc == OP_HALT) ? HALT : EXEC;
      EXEC: begin
        if (opc == OP_BEQ || opc == OP_BNE) begin
          PCWrite = take_branch;
          PCSrc   = take_branch ? 2'd1 : 2'd0;
          nxt     = FETCH;
        end else if (opc == OP_J) begin
          PCWrite = 1'b1;
          PCSrc   = 2'd2;
          nxt     = FETCH;
        end else if (opc == OP_JAL) begin
          PCWrite = 1'b1;
          PCSrc   = 2'd2;
          nxt     = WB;
        end else if (is_lw || is_sw) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        dREN = is_lw;
        dWEN = is_sw && !is_lw;
        if (!is_lw && !is_sw) begin
          nxt = FETCH;
        end else if (dhit) begin
          nxt = is_lw ? WB : FETCH;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
          if (wait_nxt == WAIT_MAX) begin
            timeout_set = 1'b1;
            nxt         = HALT;
          end
        end
      end
      WB: begin
        RegWrite = 1'b1;
        MemToReg = is_lw;
        nxt      = FETCH;
      end
      HALT: begin
        halt = 1'b1;
        nxt  = HALT;
      end
      default: nxt = FETCH;
    endcase

    // While reset is held, only the fetch request may be visible.
    if (!nRST) begin
      iREN     = 1'b1;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'd0;
      RegWrite = 1'b0;
      MemToReg = 1'b0;
      halt     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cur      <= FETCH;
      wait_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      if (timeout_set) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected cycle
// traces built from the instruction semantics, with randomized hit timing.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        ihit = 1'b0;
  logic        dhit = 1'b0;
  logic        zero = 1'b0;
  logic        iREN, dREN, dWEN, IRWrite, PCWrite, ExtOp, ALUSrc;
  logic        RegWrite, MemToReg, halt, timeout;
  logic [1:0]  PCSrc;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3,
                         S_W = 3'd4, S_H = 3'd5;

  multicycle_control #(.WAIT_MAX(8'd4)) dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit),
    .zero(zero), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .halt(halt), .timeout(timeout), .PCSrc(PCSrc),
    .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  st;
    logic        hi;
    logic        hd;
    logic [11:0] outs;
  } row_t;

  row_t       exp_q[$];
  logic [5:0] op_list [0:14];

  function automatic logic [11:0] ov(logic iren, logic dren, logic dwen,
                                     logic irw, logic pcw, logic [1:0] pcs,
                                     logic rw, logic m2r, logic hlt, logic to);
    return {iren, dren, dwen, irw, pcw, pcs, rw, m2r, hlt, to};
  endfunction

  function automatic logic [11:0] act_outs();
    return {iREN, dREN, dWEN, IRWrite, PCWrite, PCSrc, RegWrite, MemToReg, halt, timeout};
  endfunction

  function automatic logic exp_ext(logic [5:0] op);
    return (op == 6'h09 || op == 6'h0A || op == 6'h0B || op == 6'h23 ||
            op == 6'h2B || op == 6'h04 || op == 6'h05);
  endfunction

  function automatic logic exp_als(logic [5:0] op);
    return ((op >= 6'h09 && op <= 6'h0F) || op == 6'h23 || op == 6'h2B);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(logic [2:0] st, logic hi, logic hd, logic [11:0] o);
    row_t r;
    r.st = st; r.hi = hi; r.hd = hd; r.outs = o;
    exp_q.push_back(r);
  endtask

  // Drive and check each queued row, one clock per row; caller starts at posedge+1.
  task automatic play(string name);
    logic [5:0] op;
    op = instr[31:26];
    foreach (exp_q[i]) begin
      ihit = exp_q[i].hi;
      dhit = exp_q[i].hd;
      #1;
      checks++;
      if (state !== exp_q[i].st || act_outs() !== exp_q[i].outs) begin
        errors++;
        $display("FAIL %s row %0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 name, i, state, act_outs(), exp_q[i].st, exp_q[i].outs);
      end
      if (exp_q[i].st != S_H) begin
        checks++;
        if ({ExtOp, ALUSrc} !== {exp_ext(op), exp_als(op)}) begin
          errors++;
          $display("FAIL %s row %0d ext/alusrc: got %b%b expected %b%b",
                   name, i, ExtOp, ALUSrc, exp_ext(op), exp_als(op));
        end
      end
      @(posedge CLK); #1;
    end
    exp_q.delete();
  endtask

  // Expected trace of one instruction from its semantics; di/dd are miss cycles before the hit.
  task automatic run_instr(string name, logic [31:0] ins, logic z, int di, int dd);
    logic [5:0] op;
    logic lw, sw, br, jmp;
    instr = ins;
    zero  = z;
    op    = ins[31:26];
    lw    = (op == 6'h23);
    sw    = (op == 6'h2B);
    exp_q.delete();
    for (int k = 0; k <= di; k++)
      push(S_F, k == di, rbit(), ov(1, 0, 0, k == di, k == di, 2'd0, 0, 0, 0, 0));
    push(S_D, rbit(), rbit(), ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    if (op == 6'h3F) begin
      push(S_H, rbit(), rbit(), ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0));
    end else begin
      br  = ((op == 6'h04) && z) || ((op == 6'h05) && !z);
      jmp = (op == 6'h02) || (op == 6'h03);
      push(S_E, rbit(), rbit(),
           ov(0, 0, 0, 0, br | jmp, jmp ? 2'd2 : (br ? 2'd1 : 2'd0), 0, 0, 0, 0));
      if (lw || sw)
        for (int k = 0; k <= dd; k++)
          push(S_M, rbit(), k == dd, ov(0, lw, sw, 0, 0, 2'd0, 0, 0, 0, 0));
      if (!(op == 6'h04 || op == 6'h05 || op == 6'h02 || sw))
        push(S_W, rbit(), rbit(), ov(0, 0, 0, 0, 0, 2'd0, 1, lw, 0, 0));
    end
    play(name);
  endtask

  task automatic apply_reset();
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (state !== S_F || act_outs() !== ov(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset: state=%0d outs=%b, expected state=0 outs=%b",
               state, act_outs(), ov(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    end
    ihit = 1'b0; dhit = 1'b0;
    nRST = 1'b1;
  endtask

  task automatic test_alu();
    run_instr("addiu", 32'h2401FFFF, 1'b0, 1, 0);
    run_instr("ori",   32'h3401FFFF, 1'b0, 1, 0);
    run_instr("rtype", 32'h00221820, 1'b1, 0, 0);
  endtask

  task automatic test_mem();
    run_instr("lw_dhit3", 32'h8C220004, 1'b0, 0, 3);
    run_instr("sw_dhit0", 32'hAC220008, 1'b0, 2, 0);
    run_instr("lw_imiss3", 32'h8C230000, 1'b0, 3, 1);
  endtask

  task automatic test_branch_jump();
    run_instr("beq_taken",    32'h10220003, 1'b1, 0, 0);
    run_instr("beq_nottaken", 32'h10220003, 1'b0, 0, 0);
    run_instr("bne_taken",    32'h14220003, 1'b0, 1, 0);
    run_instr("bne_nottaken", 32'h14220003, 1'b1, 0, 0);
    run_instr("j",            32'h08000010, 1'b0, 0, 0);
    run_instr("jal",          32'h0C000010, 1'b1, 2, 0);
  endtask

  task automatic test_random();
    logic [31:0] rnd;
    for (int n = 0; n < 40; n++) begin
      rnd = $urandom();
      run_instr("random", {op_list[$urandom_range(0, 14)], rnd[25:0]},
                rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic check_cleared(string name);
    checks++;
    if (state !== S_F || timeout !== 1'b0 || halt !== 1'b0) begin
      errors++;
      $display("FAIL %s: state=%0d timeout=%b halt=%b, expected 0/0/0",
               name, state, timeout, halt);
    end
  endtask

  task automatic test_timeout_fetch();
    instr = 32'h2401FFFF;
    for (int k = 0; k < 4; k++)
      push(S_F, 1'b0, rbit(), ov(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    push(S_H, 1'b1, rbit(), ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 1));
    push(S_H, rbit(), rbit(), ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 1));
    play("timeout_fetch");
    apply_reset();
    check_cleared("timeout_fetch_reset");
  endtask

  task automatic test_timeout_mem();
    instr = 32'hAC220008;
    push(S_F, 1'b1, 1'b0, ov(1, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0));
    push(S_D, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    push(S_E, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      push(S_M, rbit(), 1'b0, ov(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0));
    push(S_H, rbit(), rbit(), ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 1));
    play("timeout_mem");
    apply_reset();
    check_cleared("timeout_mem_reset");
  endtask

  task automatic test_reset_mid_mem();
    instr = 32'h8C220004;
    push(S_F, 1'b1, 1'b0, ov(1, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0));
    push(S_D, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    push(S_E, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    push(S_M, 1'b0, 1'b0, ov(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    play("mid_mem_setup");
    ihit = 1'b0; dhit = 1'b1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (state !== S_F || act_outs() !== ov(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid_mem: state=%0d outs=%b, expected state=0 outs=%b",
               state, act_outs(), ov(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    end
    dhit = 1'b0;
    nRST = 1'b1;
    #1;
    run_instr("after_mid_mem", 32'h2401FFFF, 1'b0, 0, 0);
  endtask

  task automatic test_halt();
    run_instr("halt_entry", 32'hFC000000, 1'b0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      ihit = rbit(); dhit = rbit(); zero = rbit();
      #1;
      checks++;
      if (state !== S_H || act_outs() !== ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0)) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: state=%0d outs=%b, expected state=5 outs=%b",
                 k, state, act_outs(), ov(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0));
      end
      @(posedge CLK); #1;
    end
    apply_reset();
    check_cleared("halt_reset");
  endtask

  initial begin
    op_list[0]  = 6'h00; op_list[1]  = 6'h09; op_list[2]  = 6'h0A;
    op_list[3]  = 6'h0B; op_list[4]  = 6'h0C; op_list[5]  = 6'h0D;
    op_list[6]  = 6'h0E; op_list[7]  = 6'h0F; op_list[8]  = 6'h23;
    op_list[9]  = 6'h2B; op_list[10] = 6'h04; op_list[11] = 6'h05;
    op_list[12] = 6'h02; op_list[13] = 6'h03; op_list[14] = 6'h1C;
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_random();
    test_reset_mid_mem();
    test_timeout_fetch();
    test_timeout_mem();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
